fetch_sequencer: RTL and testbench

//  Fetch-stage controller that owns PC_F and sequences the next-PC mux output into a

---
 rtl/fetch_sequencer_pkg.sv | 17 +
 rtl/fetch_sequencer_pc_redirect_latch.sv | 26 ++
 rtl/fetch_sequencer.sv | 81 ++++++++
 tb/tb_fetch_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: reset PC, word width, FSM encoding
// and the word-alignment helper used for instruction-memory addresses.
package fetch_sequencer_pkg;

    localparam int INSTR_W = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic {
        FETCH = 1'b0,
        BUF   = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] word_addr(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_redirect_latch.sv
// Holds a redirect target that arrived while F could not yet advance, so it is
// applied once the delay-slot word has been handed to D.
module pc_redirect_latch (
    input  logic        clk,
    input  logic        reset,
    input  logic        set,
    input  logic        clear,
    input  logic [31:0] target,
    output logic        pend_valid,
    output logic [31:0] pend_target
);

    // clear wins: the consuming edge has already routed any redirect into PC_F
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (clear) begin
            pend_valid  <= 1'b0;
        end else if (set) begin
            pend_valid  <= 1'b1;
            pend_target <= target;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns PC_F, issues req/ack fetches to instruction memory,
// buffers the word for F/D and defers redirects until the delay slot is delivered.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        npc,
    output logic               im_req,
    output logic [31:0]        im_addr,
    input  logic               im_ack,
    input  logic [INSTR_W-1:0] im_rdata,
    output logic               valid_F,
    output logic [INSTR_W-1:0] instr_F,
    output logic [31:0]        PC_F,
    output fetch_state_t       state,
    output logic               pend_valid
);

    fetch_state_t       state_next;
    logic [INSTR_W-1:0] ibuf;
    logic [31:0]        pend_target;
    logic [31:0]        next_pc;
    logic               consume;
    logic               capture;

    // consume: F/D takes the buffered word on this edge
    assign consume = (state == BUF) && !stall;
    assign capture = redirect && !consume;

    always_comb begin
        state_next = state;
        next_pc    = PC_F + 32'd4;
        if (redirect) begin
            next_pc = npc;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end
        case (state)
            FETCH:   if (im_ack) state_next = BUF;
            BUF:     if (!stall) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            PC_F  <= RESET_PC;
            ibuf  <= '0;
        end else begin
            state <= state_next;
            if (state == FETCH && im_ack) begin
                ibuf <= im_rdata;
            end
            if (consume) begin
                PC_F <= next_pc;
            end
        end
    end

    assign im_req  = (state == FETCH);
    assign im_addr = word_addr(PC_F);
    assign valid_F = (state == BUF);
    assign instr_F = ibuf;

    pc_redirect_latch u_redirect_latch (
        .clk         (clk),
        .reset       (reset),
        .set         (capture),
        .clear       (consume),
        .target      (npc),
        .pend_valid  (pend_valid),
        .pend_target (pend_target)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: an instruction memory with programmable wait states and
// a program-order model of which PC must be delivered next and when.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         stall = 1'b0;
    logic         redirect = 1'b0;
    logic [31:0]  npc = '0;
    logic         im_req;
    logic [31:0]  im_addr;
    logic         im_ack;
    logic [31:0]  im_rdata;
    logic         valid_F;
    logic [31:0]  instr_F;
    logic [31:0]  PC_F;
    fetch_state_t dut_state;
    logic         dut_pend;

    fetch_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .npc        (npc),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_ack     (im_ack),
        .im_rdata   (im_rdata),
        .valid_F    (valid_F),
        .instr_F    (instr_F),
        .PC_F       (PC_F),
        .state      (dut_state),
        .pend_valid (dut_pend)
    );

    // instruction memory: contents are a fixed hash of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    int unsigned wait_n = 0;
    int unsigned wait_cnt = 0;
    assign im_ack   = im_req && (wait_cnt == wait_n);
    assign im_rdata = mem_word(im_addr);
    always @(posedge clk) begin
        if (reset || im_ack) wait_cnt <= 0;
        else if (im_req)     wait_cnt <= wait_cnt + 1;
    end

    // scoreboard
    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    logic [31:0] exp_q[$];
    logic        pend_v;
    logic [31:0] pend_t;
    logic        prev_valid;
    logic        dl_armed;
    int          cyc = 0;
    int          deadline = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(RST_PC);
        pend_v     = 1'b0;
        pend_t     = '0;
        prev_valid = 1'b0;
        dl_armed   = 1'b0;
    endtask

    // compare the current cycle against the model, then advance the model
    task automatic observe();
        logic [31:0] cur;
        cur = exp_q[0];
        check("pend_valid", {31'd0, dut_pend}, {31'd0, pend_v});
        if (valid_F) begin
            check("PC_F", PC_F, cur);
            check("instr_F", instr_F, mem_word(word_addr(cur)));
            check("im_req_in_buf", {31'd0, im_req}, 32'd0);
            if (!prev_valid && dl_armed) check("latency", cyc, deadline);
        end else begin
            check("im_req_in_fetch", {31'd0, im_req}, 32'd1);
            check("im_addr", im_addr, word_addr(cur));
        end
        if (redirect && pend_v) begin
            total_cnt++;
            $error("FAIL b2b_redirect: observed redirect with pending target %h", pend_t);
        end
        if (valid_F && !stall) begin
            void'(exp_q.pop_front());
            exp_q.push_back(redirect ? npc : (pend_v ? pend_t : cur + 32'd4));
            pend_v   = 1'b0;
            dl_armed = 1'b1;
            deadline = cyc + int'(wait_n) + 2;
        end else if (redirect) begin
            pend_v = 1'b1;
            pend_t = npc;
        end
        prev_valid = valid_F;
        cyc++;
    endtask

    // driver tasks: entered and left at negedge+1 of a cycle
    task automatic tick(input logic s, input logic r, input logic [31:0] n);
        stall    = s;
        redirect = r;
        npc      = n;
        observe();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset    = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        npc      = '0;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_PC_F", PC_F, RST_PC);
        check("rst_im_req", {31'd0, im_req}, 32'd1);
        check("rst_im_addr", im_addr, RST_PC);
        check("rst_valid_F", {31'd0, valid_F}, 32'd0);
        check("rst_instr_F", instr_F, 32'd0);
        check("rst_pend", {31'd0, dut_pend}, 32'd0);
        check("rst_state", {31'd0, dut_state}, {31'd0, FETCH});
        model_reset();
    endtask

    task automatic seek_buf(input logic [31:0] target);
        int k = 0;
        while (!(valid_F && PC_F == target) && k < 200) begin
            tick(1'b0, 1'b0, '0);
            k++;
        end
        check("seek_buf", {31'd0, valid_F && PC_F == target}, 32'd1);
    endtask

    task automatic seek_fetch(input logic [31:0] target);
        int k = 0;
        while (!(!valid_F && im_addr == target) && k < 200) begin
            tick(1'b0, 1'b0, '0);
            k++;
        end
        check("seek_fetch", {31'd0, !valid_F && im_addr == target}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned waits[4] = '{0, 1, 2, 5};
        @(negedge clk);
        #1;

        // reset state and zero-wait throughput
        wait_n = 0;
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            check("zw_valid", {31'd0, valid_F}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 1) check("zw_pc", PC_F, RST_PC + 32'(4 * (i / 2)));
            tick(1'b0, 1'b0, '0);
        end

        // stall holds the buffered word
        do_reset(1);
        seek_buf(32'h3004);
        repeat (3) begin
            tick(1'b1, 1'b0, '0);
            check("stall_pc", PC_F, 32'h3004);
            check("stall_instr", instr_F, mem_word(32'h3004));
            check("stall_req", {31'd0, im_req}, 32'd0);
        end
        tick(1'b0, 1'b0, '0);
        check("stall_release_addr", im_addr, 32'h3008);

        // redirect on the consuming edge
        do_reset(1);
        seek_buf(32'h3004);
        tick(1'b0, 1'b1, 32'h3100);
        check("redir_consume_addr", im_addr, 32'h3100);
        check("redir_consume_pend", {31'd0, dut_pend}, 32'd0);

        // redirect during a 3-wait fetch: delay slot first
        wait_n = 3;
        do_reset(1);
        seek_fetch(32'h3008);
        tick(1'b0, 1'b1, 32'h3100);
        check("redir_fetch_pend", {31'd0, dut_pend}, 32'd1);
        seek_buf(32'h3008);
        tick(1'b0, 1'b0, '0);
        check("delay_slot_then_target", im_addr, 32'h3100);
        check("delay_slot_pend_clear", {31'd0, dut_pend}, 32'd0);

        // reset while waiting on memory
        do_reset(1);
        seek_fetch(32'h3010);
        tick(1'b0, 1'b0, '0);
        do_reset(1);

        // wraparound and unaligned target
        wait_n = 1;
        do_reset(1);
        seek_buf(RST_PC);
        tick(1'b0, 1'b1, 32'hFFFF_FFFC);
        seek_buf(32'hFFFF_FFFC);
        tick(1'b0, 1'b0, '0);
        check("wrap_addr", im_addr, 32'h0000_0000);
        seek_buf(32'h0000_0000);
        tick(1'b0, 1'b1, 32'h0000_4002);
        check("unaligned_pc", PC_F, 32'h0000_4002);
        check("unaligned_addr", im_addr, 32'h0000_4000);

        // randomized stall/redirect traffic across memory latencies
        foreach (waits[w]) begin
            wait_n = waits[w];
            do_reset(1 + $urandom_range(0, 1));
            repeat (150) begin
                logic        s;
                logic        r;
                logic [31:0] n;
                s = ($urandom_range(0, 99) < 30);
                r = !pend_v && ($urandom_range(0, 99) < 15);
                n = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
                tick(s, r, n);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
